// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding and a helper for sizing the bit counter.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;

  // Counter must hold 0..WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// One-bit full adder built from two half adders and an OR of their carries.
// Ports:
//   halfadder:      a, b -> s (sum), c (carry)
//   full_adder_bit: a, b, cin -> sum, cout
// Both modules are purely combinational.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  halfadder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  halfadder u_ha1 (
    .a (s0),
    .b (cin),
    .s (sum),
    .c (c1)
  );

  // At most one of the two half-adder carries can be set.
  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: on an accepted start, adds A and B LSB first, one bit per
// clock, then pulses done for one cycle with S/Cout valid and held.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - add request, honoured only in IDLE
//   A, B  - operands, captured on the accepting edge
//   busy  - high while in RUN
//   done  - one-cycle pulse in DONE
//   S     - sum, held until the next accepted start
//   Cout  - carry out of the MSB, held with S
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             busy_next;
  logic             done_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             sum_bit;
  logic             carry_bit;

  full_adder_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (sum_bit),
    .cout (carry_bit)
  );

  assign last_bit = (cnt == LAST);

  // State register; busy/done are registered alongside so they track state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state logic; the unused code falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the flops equal the state decode.
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  // Serial datapath: operands shift right, sum bits enter S at the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
          end
        end
        RUN: begin
          S     <= (S >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
          carry <= carry_bit;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (last_bit) Cout <= carry_bit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH = 8, 1 and 16.
// A behavioural model tracks each instance's expected busy/done timing and
// pushes the expected {Cout,S} on every accepted start; a monitor pops and
// compares when done is seen.
module tb_serial_adder_ctrl;

  localparam int unsigned W0 = 8;
  localparam int unsigned W1 = 1;
  localparam int unsigned W2 = 16;

  typedef struct {
    logic [32:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];

  logic        busy8, done8, cout8;
  logic [7:0]  s8;
  logic        busy1, done1, cout1;
  logic [0:0]  s1;
  logic        busy16, done16, cout16;
  logic [15:0] s16;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W0)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0][7:0]), .B(b_v[0][7:0]),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(W1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1][0:0]), .B(b_v[1][0:0]),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
  );

  serial_adder_ctrl #(.WIDTH(W2)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2][15:0]), .B(b_v[2][15:0]),
    .busy(busy16), .done(done16), .S(s16), .Cout(cout16)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned wid(input int i);
    case (i)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  function automatic logic [32:0] obs_res(input int i);
    case (i)
      0:       return 33'({cout8, s8});
      1:       return 33'({cout1, s1});
      default: return 33'({cout16, s16});
    endcase
  endfunction

  function automatic logic obs_busy(input int i);
    case (i)
      0:       return busy8;
      1:       return busy1;
      default: return busy16;
    endcase
  endfunction

  function automatic logic obs_done(input int i);
    case (i)
      0:       return done8;
      1:       return done1;
      default: return done16;
    endcase
  endfunction

  // Scoreboard queues, one per instance.
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  function automatic void push_exp(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Reference timing model: RUN lasts WIDTH cycles, then one DONE cycle.
  int          run_left [3];
  bit          dn [3];
  int          nres [3];
  logic [32:0] last [3];
  int          cyc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        run_left[i] = 0;
        dn[i]       = 1'b0;
        last[i]     = '0;
      end
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          dn[i] = 1'b0;
        end else if (run_left[i] != 0) begin
          run_left[i]--;
          if (run_left[i] == 0) dn[i] = 1'b1;
        end else if (start_v[i]) begin
          exp_t        e;
          logic [63:0] mask;
          logic [63:0] sum;
          mask  = (64'd1 << wid(i)) - 64'd1;
          sum   = (64'(a_v[i]) & mask) + (64'(b_v[i]) & mask);
          e.res = 33'(sum);
          e.cyc = cyc;
          push_exp(i, e);
          run_left[i] = int'(wid(i));
        end
      end
    end
  end

  // Monitor: status every cycle, results on done, held result when idle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("busy_w%0d", wid(i)), 64'(obs_busy(i)), 64'(run_left[i] != 0));
        check($sformatf("done_w%0d", wid(i)), 64'(obs_done(i)), 64'(dn[i]));
        if (obs_done(i)) begin
          if (q_size(i) == 0) begin
            check($sformatf("spurious_done_w%0d", wid(i)), 64'(1), 64'(0));
          end else begin
            exp_t e;
            e = pop_exp(i);
            nres[i]++;
            check($sformatf("sum_w%0d", wid(i)), 64'(obs_res(i)), 64'(e.res));
            check($sformatf("latency_w%0d", wid(i)), 64'(cyc - e.cyc), 64'(wid(i)));
            last[i] = e.res;
          end
        end else if (run_left[i] == 0 && !dn[i]) begin
          check($sformatf("hold_w%0d", wid(i)), 64'(obs_res(i)), 64'(last[i]));
        end
      end
    end
  end

  // Issue one add at a negedge while idle; returns at the first idle negedge after done.
  task automatic run_op(input int i, input logic [31:0] av, input logic [31:0] bv);
    int n;
    a_v[i]     = av;
    b_v[i]     = bv;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    n = 0;
    while (!dn[i] && n < 100) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
      @(negedge clk);
      n++;
    end
    if (!dn[i]) check($sformatf("timeout_w%0d", wid(i)), 64'(0), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
      last[i]    = '0;
      nres[i]    = 0;
    end

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'(0));
    check("rst_done8", 64'(done8), 64'(0));
    check("rst_res8", 64'({cout8, s8}), 64'(0));
    check("rst_res16", 64'({cout16, s16}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic add.
    run_op(0, 32'h0F, 32'h01);
    check("v_0f_01", 64'({cout8, s8}), 64'h010);

    // Overflow then back-to-back with a single idle cycle.
    run_op(0, 32'hFF, 32'h01);
    check("v_ff_01", 64'({cout8, s8}), 64'h100);
    run_op(0, 32'hFF, 32'hFF);
    check("v_ff_ff", 64'({cout8, s8}), 64'h1FE);

    // Start held high, operands changing: exactly one result.
    r0 = nres[0];
    a_v[0] = 32'h3C;
    b_v[0] = 32'h5A;
    start_v[0] = 1'b1;
    repeat (W0 + 2) begin
      @(negedge clk);
      a_v[0] = $urandom;
      b_v[0] = $urandom;
    end
    start_v[0] = 1'b0;
    @(negedge clk);
    check("held_start_count", 64'(nres[0] - r0), 64'(1));
    check("held_start_sum", 64'({cout8, s8}), 64'h096);

    // Async reset mid-operation.
    a_v[0] = 32'h5A;
    b_v[0] = 32'h33;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy8", 64'(busy8), 64'(0));
    check("arst_done8", 64'(done8), 64'(0));
    check("arst_res8", 64'({cout8, s8}), 64'(0));
    #1 rst = 1'b0;
    r0 = nres[0];
    repeat (W0 + 3) @(negedge clk);
    check("arst_no_done", 64'(nres[0] - r0), 64'(0));
    run_op(0, 32'h80, 32'h80);
    check("v_80_80", 64'({cout8, s8}), 64'h100);

    // WIDTH=1 exhaustive.
    run_op(1, 32'h0, 32'h0);
    check("w1_00", 64'({cout1, s1}), 64'b00);
    run_op(1, 32'h0, 32'h1);
    check("w1_01", 64'({cout1, s1}), 64'b01);
    run_op(1, 32'h1, 32'h0);
    check("w1_10", 64'({cout1, s1}), 64'b01);
    run_op(1, 32'h1, 32'h1);
    check("w1_11", 64'({cout1, s1}), 64'b10);

    // WIDTH=16 random regression.
    r0 = nres[2];
    for (int k = 0; k < 1000; k++) begin
      run_op(2, $urandom, $urandom);
    end
    check("w16_count", 64'(nres[2] - r0), 64'(1000));

    repeat (3) @(negedge clk);
    check("q_empty", 64'(q_size(0) + q_size(1) + q_size(2)), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, giving the operand width in bits; legal range is 1 to 32.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  request to add A and B; sampled only in IDLE.
REQ-005 A  input  WIDTH  first operand; captured on the accepting edge.
REQ-006 B  input  WIDTH  second operand; captured on the accepting edge.
REQ-007 busy  output  1  high while the addition is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse meaning S and Cout are valid (DONE state).
REQ-009 S  output  WIDTH  sum; registered and held until the next accepted start.
REQ-010 Cout  output  1  carry out of the MSB; registered and held with S.

Function
REQ-011 The block SHALL add A and B bit-serially, LSB first, using one 1-bit full-adder cell per clock cycle.
REQ-012 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE to RUN: on a rising edge with start=1, the block SHALL capture A and B into shift registers, clear the carry register and the bit counter, and clear S and Cout to 0.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-015 In RUN, each edge SHALL:
- add the two operand LSBs and the carry register;
- shift the sum bit into S from the MSB end (S shifts right);
- update the carry register;
- shift both operand registers right;
- increment the bit counter.
REQ-016 RUN to DONE: on the edge that processes bit WIDTH-1, the block SHALL load Cout from the final carry and move to DONE.
REQ-017 DONE to IDLE: the block SHALL return to IDLE unconditionally on the next edge.
REQ-018 Latency: if start is captured at edge k, done SHALL be high exactly during the cycle after edge k+WIDTH and low otherwise.
REQ-019 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE); both SHALL be glitch-free registered-state decodes.
REQ-020 start SHALL be ignored in RUN and DONE, with no queuing; changes on A and B after capture SHALL have no effect.
REQ-021 Back-to-back operation: a start asserted in the first IDLE cycle after DONE SHALL be accepted, so the minimum issue interval is WIDTH+2 cycles.
REQ-022 The result SHALL equal (A+B) mod 2^WIDTH on S, with Cout equal to bit WIDTH of the true sum.
REQ-023 When WIDTH=1, RUN SHALL last exactly one cycle.
REQ-024 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap during an operation.

Reset
REQ-025 Asserting rst SHALL, immediately and regardless of clk, force the following: state=IDLE, S=0, Cout=0, busy=0, done=0, carry=0, counter=0, and operand registers=0.
REQ-026 Asserting rst mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-028 The state encoding SHALL live in the shared package serial_adder_pkg as localparams IDLE=2'b00, RUN=2'b01 and DONE=2'b10; unused code 2'b11 SHALL recover to IDLE on the next edge.
REQ-029 The per-bit full adder SHALL be one sub-module, full_adder_bit, built from two halfadder instances plus an OR on the two carries.
REQ-030 No other sub-modules SHALL be used; the full_adder_bit instance SHALL be purely combinational.

Verification
REQ-031 WIDTH=8, A=8'h0F, B=8'h01, start pulse -> S=8'h10, Cout=0, done high exactly the 8th cycle after capture, busy high 8 cycles.
REQ-032 WIDTH=8, A=8'hFF, B=8'h01 -> S=8'h00, Cout=1; then A=8'hFF, B=8'hFF on the next IDLE cycle -> S=8'hFE, Cout=1, with no idle gap beyond one cycle.
REQ-033 WIDTH=8, start held high and A/B changed every cycle during RUN -> exactly one result, matching the captured operands; start in DONE is not accepted.
REQ-034 WIDTH=8, rst pulsed asynchronously at bit 4 of an add -> all outputs 0 immediately, no done; a new add of 8'h80+8'h80 gives S=8'h00, Cout=1.
REQ-035 WIDTH=1, all four operand combinations -> {Cout,S} = 00, 01, 01, 10; done in the cycle after the single RUN cycle.
REQ-036 Random WIDTH=16 regression of 1000 ops against a reference sum, with done, busy and latency checked every operation.
